// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 8-bit CPU control sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_OPR_LO,
        ST_OPR_HI,
        ST_EXEC,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_HALT
    } state_t;

    localparam logic [3:0] BR_JMP = 4'd0;
    localparam logic [3:0] BR_JZ  = 4'd1;
    localparam logic [3:0] BR_JNZ = 4'd2;
    localparam logic [3:0] BR_JC  = 4'd3;
    localparam logic [3:0] BR_JNC = 4'd4;
    localparam logic [3:0] BR_JP  = 4'd5;
    localparam logic [3:0] BR_JM  = 4'd6;
    localparam logic [3:0] BR_JPE = 4'd7;
    localparam logic [3:0] BR_JPO = 4'd8;

    localparam logic [1:0] WSEL_REG = 2'd0;
    localparam logic [1:0] WSEL_ALU = 2'd1;
    localparam logic [1:0] WSEL_IMM = 2'd2;
    localparam logic [1:0] WSEL_MEM = 2'd3;

    // Bit positions inside the {S,Z,P,C} flags vector
    localparam int FLG_S = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_P = 1;
    localparam int FLG_C = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: decides whether a branch of the
// given type is taken for the current {S,Z,P,C} flags.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] branch_type,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_type)
            BR_JMP:  taken = 1'b1;
            BR_JZ:   taken = flags[FLG_Z];
            BR_JNZ:  taken = ~flags[FLG_Z];
            BR_JC:   taken = flags[FLG_C];
            BR_JNC:  taken = ~flags[FLG_C];
            BR_JP:   taken = ~flags[FLG_S];
            BR_JM:   taken = flags[FLG_S];
            BR_JPE:  taken = flags[FLG_P];
            BR_JPO:  taken = ~flags[FLG_P];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer owning PC, IR and operand latches.
// Define CPU_CTRL_RETIRE_CNT_EN to add the retired-instruction counter output.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    input  logic [7:0]  a_value,
    output logic [7:0]  ir,
    input  logic        dec_reg_write,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_use_alu,
    input  logic        dec_use_immediate,
    input  logic        dec_halt,
    input  logic        dec_is_branch,
    input  logic [3:0]  dec_branch_type,
    input  logic [1:0]  dec_inst_length,
    input  logic [3:0]  flags,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic [7:0]  imm_data,
    output logic        flags_we,
    output logic [15:0] pc,
    output logic        instr_done,
    output logic        halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    state_t      state, state_nx;
    logic [7:0]  opr_lo, opr_hi, ld_data;
    logic        rst_q;
    logic        ld_ir, ld_lo, ld_hi, ld_rd, pc_inc, pc_jump;
    logic        br_taken;

    branch_cond_eval u_branch_cond_eval (
        .branch_type (dec_branch_type),
        .flags       (flags),
        .taken       (br_taken)
    );

    assign mem_wdata = a_value;

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        rf_we      = 1'b0;
        rf_wsel    = WSEL_REG;
        imm_data   = opr_lo;
        flags_we   = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        ld_ir      = 1'b0;
        ld_lo      = 1'b0;
        ld_hi      = 1'b0;
        ld_rd      = 1'b0;
        pc_inc     = 1'b0;
        pc_jump    = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ld_ir    = 1'b1;
                    pc_inc   = 1'b1;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_halt) begin
                    instr_done = 1'b1;
                    state_nx   = ST_HALT;
                end else if (dec_inst_length >= 2'd2) begin
                    state_nx = ST_OPR_LO;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_OPR_LO: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ld_lo    = 1'b1;
                    pc_inc   = 1'b1;
                    state_nx = (dec_inst_length == 2'd3) ? ST_OPR_HI : ST_EXEC;
                end
            end
            ST_OPR_HI: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ld_hi    = 1'b1;
                    pc_inc   = 1'b1;
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec_mem_read) begin
                    state_nx = ST_MEM_RD;
                end else if (dec_mem_write) begin
                    state_nx = ST_MEM_WR;
                end else if (dec_is_branch) begin
                    pc_jump    = br_taken;
                    instr_done = 1'b1;
                    state_nx   = ST_FETCH;
                end else begin
                    // CMP-style ops have use_alu without reg_write: flags only
                    rf_we      = dec_reg_write;
                    rf_wsel    = dec_use_alu ? WSEL_ALU :
                                 dec_use_immediate ? WSEL_IMM : WSEL_REG;
                    flags_we   = dec_use_alu;
                    instr_done = 1'b1;
                    state_nx   = ST_FETCH;
                end
            end
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = {opr_hi, opr_lo};
                if (mem_ready) begin
                    ld_rd    = 1'b1;
                    state_nx = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                rf_we      = 1'b1;
                rf_wsel    = WSEL_MEM;
                imm_data   = ld_data;
                instr_done = 1'b1;
                state_nx   = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {opr_hi, opr_lo};
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_nx   = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_nx = ST_FETCH;
        endcase
        // The reset state is FETCH, so strobes are held off for the cycle after rst is sampled
        if (rst_q) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            rf_we      = 1'b0;
            flags_we   = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            ir      <= 8'h00;
            opr_lo  <= 8'h00;
            opr_hi  <= 8'h00;
            ld_data <= 8'h00;
        end else begin
            state <= state_nx;
            if (ld_ir) ir <= mem_rdata;
            if (ld_lo) opr_lo <= mem_rdata;
            if (ld_hi) opr_hi <= mem_rdata;
            if (ld_rd) ld_data <= mem_rdata;
            if (pc_jump) pc <= {opr_hi, opr_lo};
            else if (pc_inc) pc <= pc + 16'd1;
        end
    end

`ifdef CPU_CTRL_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) retired_cnt <= '0;
        else if (instr_done) retired_cnt <= retired_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle sequencer for the 8-bit CPU core. Owns PC, IR and the operand-address latch. Drives the instruction decoder with IR and consumes its control outputs. Issues the memory request/ready handshake, register-file write enables, flag updates and branch resolution. Sits between the memory port, the decoder, the register file and the ALU.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
CNT_W, 32, width of the retired-instruction counter (used only when the optional feature is enabled)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mem_req  out  1  memory access request; held until mem_ready
mem_we  out  1  write qualifier for mem_req
mem_addr  out  16  access address
mem_wdata  out  8  store data; equals a_value
mem_ready  in  1  access complete; mem_rdata valid this cycle
mem_rdata  in  8  read data
a_value  in  8  accumulator contents from the register file
ir  out  8  instruction register, to the decoder
dec_reg_write, dec_mem_read, dec_mem_write, dec_use_alu, dec_use_immediate, dec_halt, dec_is_branch  in  1 each  decoder controls
dec_branch_type  in  4  0=JMP 1=JZ 2=JNZ 3=JC 4=JNC 5=JP 6=JM 7=JPE 8=JPO
dec_inst_length  in  2  instruction length in bytes: 1, 2 or 3
flags  in  4  {S,Z,P,C}
rf_we  out  1  register-file write strobe
rf_wsel  out  2  write source: 0=reg(MOV) 1=ALU 2=immediate 3=memory data
imm_data  out  8  operand byte 1, or the latched load data when rf_wsel=3
flags_we  out  1  ALU flag-register update strobe
pc  out  16  program counter
instr_done  out  1  one-cycle pulse on the last cycle of every instruction
halted  out  1  high in HALT

Behaviour:
- Reset (synchronous): state=FETCH, pc=RESET_PC, ir=8'h00, operand latches=0. All strobes (mem_req, mem_we, rf_we, flags_we, instr_done) are 0; halted=0. Reset takes effect mid-access: mem_req deasserts the cycle after rst is sampled, and any pending mem_ready is ignored.
- States: FETCH, DECODE, OPR_LO, OPR_HI, EXEC, MEM_RD, MEM_WB, MEM_WR, HALT.
- FETCH: mem_req=1, mem_addr=pc. On mem_ready: ir<=mem_rdata, pc<=pc+1, go to DECODE.
- DECODE (1 cycle):
  - dec_halt -> HALT, with instr_done.
  - else dec_inst_length>=2 -> OPR_LO.
  - else -> EXEC.
- OPR_LO: fetch at pc; on ready: lo<=mem_rdata, pc++. Length 3 -> OPR_HI; else -> EXEC.
- OPR_HI: same as OPR_LO, latching hi, then -> EXEC.
- EXEC:
  - mem_read -> MEM_RD.
  - mem_write -> MEM_WR.
  - is_branch: if taken, pc<={hi,lo}; instr_done; -> FETCH.
  - else: rf_we=dec_reg_write; rf_wsel = use_alu?1 : use_immediate?2 : 0; flags_we=dec_use_alu (CMP updates flags only); instr_done; -> FETCH.
- Branch taken conditions: JMP always; JZ Z; JNZ !Z; JC C; JNC !C; JP !S; JM S; JPE P; JPO !P. Types 9-15 are never taken.
- MEM_RD: mem_req=1, addr={hi,lo}. On ready, latch data -> MEM_WB.
- MEM_WB: rf_we=1, rf_wsel=3, instr_done; -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr={hi,lo}, wdata=a_value. On ready: instr_done; -> FETCH.
- HALT: absorbing state, halted=1, no memory requests; exited only by rst.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and !mem_ready. Memory-wait states have no timeout.
- PC arithmetic is modulo 2^16 (16'hFFFF+1=16'h0000). Operand-fetch addresses wrap the same way.
- Unknown opcodes (all decoder outputs 0, length 1) execute as a 3-cycle NOP.
- Minimum cycles with zero-wait memory: reg/ALU 3, MVI 4, JMP/Jcc 5, STA 6, LDA 7.

Optional Feature:
CPU_CTRL_RETIRE_CNT_EN
- Enabled: adds output retired_cnt [CNT_W-1:0]. It increments on every instr_done (HLT included), is reset to 0 by rst, and wraps at 2^CNT_W.
- Disabled: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cpu_pkg holds the state enum, the branch-type constants (BR_JMP..BR_JPO), the rf_wsel encodings (WSEL_REG/ALU/IMM/MEM) and the flag bit indices (FLG_S/Z/P/C).
- One sub-module, branch_cond_eval: combinational; inputs branch_type and flags, output taken. It is unit-tested separately.

Test Plan:
- rst held 2 cycles while mem_req is pending, then released -> pc=16'h0000, FETCH request at address 0, no instr_done.
- Memory 00:3E 55 (MVI A,55h), 02:87 (ADD A), zero-wait -> rf_we with wsel=2 and imm_data=8'h55 on cycle 4; rf_we with wsel=1 and flags_we on cycle 7.
- LDA 1234h with mem_ready delayed 3 cycles on the data read -> mem_addr=16'h1234 stable for 4 cycles; rf_we with wsel=3 and imm_data=read data one cycle after ready; instr_done count=1.
- JZ 0040h with Z=0, then with Z=1 -> pc=16'h0003, then pc=16'h0040.
- PC=16'hFFFF fetching a 1-byte NOP -> the next fetch address is 16'h0000.
- HLT (8'h76) -> halted=1 after DECODE, no mem_req for 20 cycles; rst clears it. With CPU_CTRL_RETIRE_CNT_EN, retired_cnt equals the number of instr_done pulses.
